// File: rtl/cr16_pkg.sv
// Shared CR16 types: arbiter FSM state encoding and
// requester index constants for the BRAM port arbiter.
package cr16_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_0 = 2'd1,
        GRANT_1 = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_EXT = 1'b1;

endpackage

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A between the CR16 core (req 0)
// and the loader/debug port (req 1), with a bounded hold per grant.
// Ports:
//   I_CLK, I_RESET                   clock, sync active-high reset
//   I_REQ_x, I_ADDRESS_x, I_DATA_x,
//   I_WRITE_ENABLE_x                 requester x access (x = 0, 1)
//   O_GRANT_x                        registered grant, decoded from state
//   O_DATA_x, O_DATA_VALID_x         read data and one-cycle valid strobe
//   O_MEM_ADDRESS, O_MEM_DATA,
//   O_MEM_WRITE_ENABLE, I_MEM_DATA   BRAM port A
module bram_port_arbiter
    import cr16_pkg::*;
#(
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 16,
    parameter int P_MAX_HOLD      = 4
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,

    input  logic                       I_REQ_0,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_0,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_0,
    input  logic                       I_WRITE_ENABLE_0,

    input  logic                       I_REQ_1,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_1,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_1,
    input  logic                       I_WRITE_ENABLE_1,

    output logic                       O_GRANT_0,
    output logic                       O_GRANT_1,
    output logic [P_DATA_WIDTH-1:0]    O_DATA_0,
    output logic [P_DATA_WIDTH-1:0]    O_DATA_1,
    output logic                       O_DATA_VALID_0,
    output logic                       O_DATA_VALID_1,

    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
    output logic [P_DATA_WIDTH-1:0]    O_MEM_DATA,
    output logic                       O_MEM_WRITE_ENABLE,
    input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA
);

    // One bit minimum so P_MAX_HOLD = 1 still elaborates.
    localparam int HOLD_W = (P_MAX_HOLD > 1) ? $clog2(P_MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(P_MAX_HOLD - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [HOLD_W-1:0] hold_count;
    logic [HOLD_W-1:0] hold_next;
    logic              last_served;
    logic              last_next;

    logic              grant_0;
    logic              grant_1;
    logic              accept_0;
    logic              accept_1;
    logic              valid_0_q;
    logic              valid_1_q;

    assign grant_0  = (state == GRANT_0);
    assign grant_1  = (state == GRANT_1);
    assign accept_0 = I_REQ_0 && grant_0;
    assign accept_1 = I_REQ_1 && grant_1;

    assign O_GRANT_0      = grant_0;
    assign O_GRANT_1      = grant_1;
    assign O_DATA_0       = I_MEM_DATA;
    assign O_DATA_1       = I_MEM_DATA;
    assign O_DATA_VALID_0 = valid_0_q;
    assign O_DATA_VALID_1 = valid_1_q;

    // Port mux: follows the grant combinationally, so a write
    // accepted during a reset cycle still reaches the BRAM.
    always_comb begin
        O_MEM_ADDRESS      = '0;
        O_MEM_DATA         = '0;
        O_MEM_WRITE_ENABLE = 1'b0;
        if (grant_0) begin
            O_MEM_ADDRESS      = I_ADDRESS_0;
            O_MEM_DATA         = I_DATA_0;
            O_MEM_WRITE_ENABLE = I_WRITE_ENABLE_0 && accept_0;
        end else if (grant_1) begin
            O_MEM_ADDRESS      = I_ADDRESS_1;
            O_MEM_DATA         = I_DATA_1;
            O_MEM_WRITE_ENABLE = I_WRITE_ENABLE_1 && accept_1;
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_count;
        last_next  = last_served;
        unique case (state)
            IDLE: begin
                if (I_REQ_0 && I_REQ_1) begin
                    // Tie goes to whoever was not served last.
                    state_next = (last_served == REQ_EXT) ? GRANT_0 : GRANT_1;
                end else if (I_REQ_0) begin
                    state_next = GRANT_0;
                end else if (I_REQ_1) begin
                    state_next = GRANT_1;
                end
            end
            GRANT_0: begin
                if (!I_REQ_0) begin
                    state_next = I_REQ_1 ? GRANT_1 : IDLE;
                end else if (I_REQ_1 && hold_count == HOLD_LAST) begin
                    state_next = GRANT_1;
                end else if (hold_count != HOLD_LAST) begin
                    hold_next = hold_count + 1'b1;
                end
            end
            GRANT_1: begin
                if (!I_REQ_1) begin
                    state_next = I_REQ_0 ? GRANT_0 : IDLE;
                end else if (I_REQ_0 && hold_count == HOLD_LAST) begin
                    state_next = GRANT_0;
                end else if (hold_count != HOLD_LAST) begin
                    hold_next = hold_count + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Any grant entry restarts the hold window and records the owner.
        if (state_next != state) begin
            hold_next = '0;
            if (state_next == GRANT_0) begin
                last_next = REQ_CPU;
            end else if (state_next == GRANT_1) begin
                last_next = REQ_EXT;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state       <= IDLE;
            hold_count  <= '0;
            last_served <= REQ_EXT;
            valid_0_q   <= 1'b0;
            valid_1_q   <= 1'b0;
        end else begin
            state       <= state_next;
            hold_count  <= hold_next;
            last_served <= last_next;
            valid_0_q   <= accept_0 && !I_WRITE_ENABLE_0;
            valid_1_q   <= accept_1 && !I_WRITE_ENABLE_1;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a one-cycle-latency
// read-first BRAM model on port A.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        g0, g1, v0, v1, mwe;
    logic [15:0] rd0, rd1, maddr, mdata;
    logic [15:0] mrdata;

    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .P_DATA_WIDTH(16),
        .P_ADDRESS_WIDTH(16),
        .P_MAX_HOLD(4)
    ) dut (
        .I_CLK(clk),
        .I_RESET(rst),
        .I_REQ_0(req0),
        .I_ADDRESS_0(addr0),
        .I_DATA_0(wdata0),
        .I_WRITE_ENABLE_0(we0),
        .I_REQ_1(req1),
        .I_ADDRESS_1(addr1),
        .I_DATA_1(wdata1),
        .I_WRITE_ENABLE_1(we1),
        .O_GRANT_0(g0),
        .O_GRANT_1(g1),
        .O_DATA_0(rd0),
        .O_DATA_1(rd1),
        .O_DATA_VALID_0(v0),
        .O_DATA_VALID_1(v1),
        .O_MEM_ADDRESS(maddr),
        .O_MEM_DATA(mdata),
        .O_MEM_WRITE_ENABLE(mwe),
        .I_MEM_DATA(mrdata)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mwe) mem[maddr[7:0]] <= mdata;
        mrdata <= mem[maddr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'h1111; addr1 = 16'h2222;
        wdata0 = 16'h3333; wdata1 = 16'h4444;
        tick(); tick();
        n_cmp++; if (g0 !== 1'b0) begin n_bad++; $display("FAIL rst_g0: got %b want 0", g0); end
        n_cmp++; if (g1 !== 1'b0) begin n_bad++; $display("FAIL rst_g1: got %b want 0", g1); end
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL rst_v0: got %b want 0", v0); end
        n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL rst_v1: got %b want 0", v1); end
        n_cmp++; if (mwe !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mwe); end
        n_cmp++; if (maddr !== 16'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0000", maddr); end
        n_cmp++; if (mdata !== 16'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0000", mdata); end
        rst = 1'b0;
        #1;
        n_cmp++; if (g0 !== 1'b0) begin n_bad++; $display("FAIL rel_g0: got %b want 0", g0); end
        tick();
        n_cmp++; if (g0 !== 1'b1) begin n_bad++; $display("FAIL first_g0: got %b want 1", g0); end
        n_cmp++; if (g1 !== 1'b0) begin n_bad++; $display("FAIL first_g1: got %b want 0", g1); end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single_read();
        pre_we = 1'b1; pre_addr = 8'h10; pre_data = 16'hBEEF;
        tick();
        pre_we = 1'b0;
        req0 = 1'b1; addr0 = 16'h0010; we0 = 1'b0;
        #1;
        n_cmp++; if (g0 !== 1'b0) begin n_bad++; $display("FAIL rd_idle_g0: got %b want 0", g0); end
        tick();
        n_cmp++; if (g0 !== 1'b1) begin n_bad++; $display("FAIL rd_g0: got %b want 1", g0); end
        n_cmp++; if (maddr !== 16'h0010) begin n_bad++; $display("FAIL rd_addr: got %h want 0010", maddr); end
        n_cmp++; if (mwe !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b want 0", mwe); end
        tick();
        req0 = 1'b0;
        #1;
        n_cmp++; if (v0 !== 1'b1) begin n_bad++; $display("FAIL rd_v0: got %b want 1", v0); end
        n_cmp++; if (rd0 !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data0: got %h want beef", rd0); end
        n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL rd_v1: got %b want 0", v1); end
        tick();
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL rd_v0_once: got %b want 0", v0); end
        n_cmp++; if (g0 !== 1'b0) begin n_bad++; $display("FAIL rd_release: got %b want 0", g0); end
    endtask

    task automatic test_write_read();
        req1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234; we1 = 1'b1;
        tick();
        n_cmp++; if (g1 !== 1'b1) begin n_bad++; $display("FAIL wr_g1: got %b want 1", g1); end
        n_cmp++; if (mwe !== 1'b1) begin n_bad++; $display("FAIL wr_we: got %b want 1", mwe); end
        n_cmp++; if (maddr !== 16'h0020) begin n_bad++; $display("FAIL wr_addr: got %h want 0020", maddr); end
        n_cmp++; if (mdata !== 16'h1234) begin n_bad++; $display("FAIL wr_data: got %h want 1234", mdata); end
        tick();
        we1 = 1'b0;
        #1;
        n_cmp++; if (mwe !== 1'b0) begin n_bad++; $display("FAIL wr_we_pulse: got %b want 0", mwe); end
        n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL wr_no_valid: got %b want 0", v1); end
        tick();
        req1 = 1'b0;
        #1;
        n_cmp++; if (v1 !== 1'b1) begin n_bad++; $display("FAIL wr_rd_v1: got %b want 1", v1); end
        n_cmp++; if (rd1 !== 16'h1234) begin n_bad++; $display("FAIL wr_rd_data1: got %h want 1234", rd1); end
        tick();
    endtask

    task automatic test_tie_and_fairness();
        int acc0;
        int acc1;
        int idle;
        logic exp_g0;
        logic [15:0] exp_addr;
        acc0 = 0; acc1 = 0; idle = 0;
        n_cmp++; if (g1 !== 1'b0) begin n_bad++; $display("FAIL tie_idle: got %b want 0", g1); end
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'h0030; addr1 = 16'h0040;
        tick();
        n_cmp++; if (g0 !== 1'b1) begin n_bad++; $display("FAIL tie_g0: got %b want 1", g0); end
        for (int i = 0; i < 16; i++) begin
            exp_g0 = ((i / 4) % 2) == 0;
            exp_addr = exp_g0 ? 16'h0030 : 16'h0040;
            n_cmp++; if (g0 !== exp_g0) begin n_bad++; $display("FAIL fair_g0[%0d]: got %b want %b", i, g0, exp_g0); end
            n_cmp++; if (g1 !== !exp_g0) begin n_bad++; $display("FAIL fair_g1[%0d]: got %b want %b", i, g1, !exp_g0); end
            n_cmp++; if (maddr !== exp_addr) begin n_bad++; $display("FAIL fair_addr[%0d]: got %h want %h", i, maddr, exp_addr); end
            if (i < 8) begin
                if (g0 && req0) acc0++;
                if (g1 && req1) acc1++;
                if (!g0 && !g1) idle++;
            end
            tick();
        end
        n_cmp++; if (acc0 !== 4) begin n_bad++; $display("FAIL fair_acc0: got %0d want 4", acc0); end
        n_cmp++; if (acc1 !== 4) begin n_bad++; $display("FAIL fair_acc1: got %0d want 4", acc1); end
        n_cmp++; if (idle !== 0) begin n_bad++; $display("FAIL fair_idle: got %0d want 0", idle); end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_hold_saturate();
        req0 = 1'b1; addr0 = 16'h0050; we0 = 1'b0;
        tick();
        repeat (6) tick();
        n_cmp++; if (g0 !== 1'b1) begin n_bad++; $display("FAIL sat_hold: got %b want 1", g0); end
        req1 = 1'b1; addr1 = 16'h0051; we1 = 1'b0;
        tick();
        n_cmp++; if (g1 !== 1'b1) begin n_bad++; $display("FAIL sat_switch: got %b want 1", g1); end
        n_cmp++; if (g0 !== 1'b0) begin n_bad++; $display("FAIL sat_drop: got %b want 0", g0); end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; addr0 = 16'h0010; we0 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (g0 !== 1'b1) begin n_bad++; $display("FAIL mid_rd_g0: got %b want 1", g0); end
        tick();
        rst = 1'b0; req0 = 1'b0;
        #1;
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL mid_rd_v0: got %b want 0", v0); end
        n_cmp++; if (g0 !== 1'b0) begin n_bad++; $display("FAIL mid_rd_g0_clr: got %b want 0", g0); end
        n_cmp++; if (g1 !== 1'b0) begin n_bad++; $display("FAIL mid_rd_g1_clr: got %b want 0", g1); end
        tick();
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL mid_rd_v0_late: got %b want 0", v0); end
    endtask

    task automatic test_reset_mid_write();
        req1 = 1'b1; addr1 = 16'h0060; wdata1 = 16'hA5A5; we1 = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (mwe !== 1'b1) begin n_bad++; $display("FAIL mid_wr_we: got %b want 1", mwe); end
        n_cmp++; if (maddr !== 16'h0060) begin n_bad++; $display("FAIL mid_wr_addr: got %h want 0060", maddr); end
        tick();
        rst = 1'b0; req1 = 1'b0; we1 = 1'b0;
        #1;
        n_cmp++; if (g1 !== 1'b0) begin n_bad++; $display("FAIL mid_wr_g1: got %b want 0", g1); end
        n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL mid_wr_v1: got %b want 0", v1); end
        req0 = 1'b1; addr0 = 16'h0060; we0 = 1'b0;
        tick();
        tick();
        req0 = 1'b0;
        #1;
        n_cmp++; if (v0 !== 1'b1) begin n_bad++; $display("FAIL mid_wr_rb_v0: got %b want 1", v0); end
        n_cmp++; if (rd0 !== 16'hA5A5) begin n_bad++; $display("FAIL mid_wr_rb_data: got %h want a5a5", rd0); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_tie_and_fairness();
        test_hold_saturate();
        test_reset_mid_read();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
